monitor_mantenimiento: RTL and testbench

MONITOR_MANTENIMIENTO -- requirements
Module: monitor_mantenimiento

---
 rtl/monitor_mantenimiento.sv | 145 ++++++++++++++
 tb/tb_monitor_mantenimiento.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_mantenimiento.sv
// Periodic maintenance-request monitor: issues a request pulse every PERIODO enabled
// cycles, checks the controller's returned status sequence and latches the first failure.
module monitor_mantenimiento #(
    parameter int         PERIODO          = 100,
    parameter int         TIEMPO_RESPUESTA = 16,
    parameter logic [7:0] CODIGO_ERROR     = 8'hFF
) (
    input  logic       reloj,
    input  logic       reset_n,
    input  logic       habilitar,
    input  logic       estado_valido,
    input  logic [7:0] estado_registro,
    input  logic       error_flag,
    input  logic       ack_operador,
    output logic       solicitud,
    output logic       alarma,
    output logic [1:0] causa,
    output logic [7:0] esperado,
    output logic [7:0] cuenta_ok,
    output logic [1:0] estado
);

    // state          | meaning
    // INACTIVO       | counting enabled cycles toward the next request
    // SOLICITANDO    | one-cycle request pulse on solicitud
    // ESPERANDO_RESP | waiting for the status strobe or the response timeout
    // FALLA          | alarm latched until the operator acknowledges
    typedef enum logic [1:0] {
        INACTIVO       = 2'b00,
        SOLICITANDO    = 2'b01,
        ESPERANDO_RESP = 2'b10,
        FALLA          = 2'b11
    } estado_t;

    localparam logic [7:0] C_FIN_PERIODO   = 8'(PERIODO - 1);
    localparam logic [7:0] C_FIN_TIMER     = 8'(TIEMPO_RESPUESTA - 1);
    localparam logic [7:0] C_ULTIMO_CODIGO = CODIGO_ERROR - 8'd1;

    localparam logic [1:0] CAUSA_NINGUNA   = 2'b00;
    localparam logic [1:0] CAUSA_ERROR     = 2'b01;
    localparam logic [1:0] CAUSA_SECUENCIA = 2'b10;
    localparam logic [1:0] CAUSA_TIMEOUT   = 2'b11;

    estado_t    r_estado;
    logic       r_solicitud;
    logic       r_alarma;
    logic [1:0] r_causa;
    logic [7:0] r_esperado;
    logic [7:0] r_cuenta_ok;
    logic [7:0] r_cnt_periodo;
    logic [7:0] r_timer;

    logic [7:0] w_siguiente;
    logic       w_fin_periodo;
    logic       w_fin_timer;
    logic       w_codigo_error;
    logic       w_codigo_ok;

    // The expected code skips CODIGO_ERROR so a good reply can never look like an error.
    assign w_siguiente    = (r_esperado == C_ULTIMO_CODIGO) ? 8'd0 : r_esperado + 8'd1;
    assign w_fin_periodo  = (r_cnt_periodo == C_FIN_PERIODO);
    assign w_fin_timer    = (r_timer == C_FIN_TIMER);
    assign w_codigo_error = (estado_registro == CODIGO_ERROR);
    assign w_codigo_ok    = (estado_registro == r_esperado);

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            r_estado      <= INACTIVO;
            r_solicitud   <= 1'b0;
            r_alarma      <= 1'b0;
            r_causa       <= CAUSA_NINGUNA;
            r_esperado    <= 8'd0;
            r_cuenta_ok   <= 8'd0;
            r_cnt_periodo <= 8'd0;
            r_timer       <= 8'd0;
        end else begin
            r_solicitud <= 1'b0;
            if ((r_estado != FALLA) && error_flag) begin
                r_estado <= FALLA;
                r_alarma <= 1'b1;
                r_causa  <= CAUSA_ERROR;
            end else begin
                case (r_estado)
                    INACTIVO: begin
                        if (habilitar) begin
                            if (w_fin_periodo) begin
                                r_cnt_periodo <= 8'd0;
                                r_estado      <= SOLICITANDO;
                                r_solicitud   <= 1'b1;
                            end else begin
                                r_cnt_periodo <= r_cnt_periodo + 8'd1;
                            end
                        end
                    end
                    SOLICITANDO: begin
                        r_estado <= ESPERANDO_RESP;
                        r_timer  <= 8'd0;
                    end
                    ESPERANDO_RESP: begin
                        // A strobe arriving on the timeout cycle still counts as a reply.
                        if (estado_valido) begin
                            if (w_codigo_error) begin
                                r_estado <= FALLA;
                                r_alarma <= 1'b1;
                                r_causa  <= CAUSA_ERROR;
                            end else if (!w_codigo_ok) begin
                                r_estado <= FALLA;
                                r_alarma <= 1'b1;
                                r_causa  <= CAUSA_SECUENCIA;
                            end else begin
                                r_estado   <= INACTIVO;
                                r_esperado <= w_siguiente;
                                if (r_cuenta_ok != 8'hFF) begin
                                    r_cuenta_ok <= r_cuenta_ok + 8'd1;
                                end
                            end
                        end else if (w_fin_timer) begin
                            r_estado <= FALLA;
                            r_alarma <= 1'b1;
                            r_causa  <= CAUSA_TIMEOUT;
                        end else begin
                            r_timer <= r_timer + 8'd1;
                        end
                    end
                    FALLA: begin
                        if (ack_operador && !error_flag) begin
                            r_estado      <= INACTIVO;
                            r_alarma      <= 1'b0;
                            r_causa       <= CAUSA_NINGUNA;
                            r_cnt_periodo <= 8'd0;
                        end
                    end
                endcase
            end
        end
    end

    assign solicitud = r_solicitud;
    assign alarma    = r_alarma;
    assign causa     = r_causa;
    assign esperado  = r_esperado;
    assign cuenta_ok = r_cuenta_ok;
    assign estado    = r_estado;

endmodule

// File: tb/tb_monitor_mantenimiento.sv
// Bench for monitor_mantenimiento: directed corners plus randomized maintenance
// transactions checked against a transaction-level model of the request/response rules.
module tb_monitor_mantenimiento;

    localparam int         PER  = 10;
    localparam int         TR   = 4;
    localparam logic [7:0] CERR = 8'hFF;

    logic       reloj = 1'b0;
    logic       reset_n = 1'b1;
    logic       habilitar = 1'b0;
    logic       estado_valido = 1'b0;
    logic [7:0] estado_registro = 8'd0;
    logic       error_flag = 1'b0;
    logic       ack_operador = 1'b0;
    logic       solicitud;
    logic       alarma;
    logic [1:0] causa;
    logic [7:0] esperado;
    logic [7:0] cuenta_ok;
    logic [1:0] estado;

    int checks = 0;
    int errors = 0;

    // Model: next expected code, success count, enabled idle cycles since last clear.
    int m_esperado = 0;
    int m_cuenta   = 0;
    int m_progreso = 0;
    int m_exitos   = 0;

    always #5 reloj = ~reloj;

    monitor_mantenimiento #(
        .PERIODO(PER),
        .TIEMPO_RESPUESTA(TR),
        .CODIGO_ERROR(CERR)
    ) dut (
        .reloj(reloj),
        .reset_n(reset_n),
        .habilitar(habilitar),
        .estado_valido(estado_valido),
        .estado_registro(estado_registro),
        .error_flag(error_flag),
        .ack_operador(ack_operador),
        .solicitud(solicitud),
        .alarma(alarma),
        .causa(causa),
        .esperado(esperado),
        .cuenta_ok(cuenta_ok),
        .estado(estado)
    );

    task automatic ciclo();
        @(posedge reloj);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resumen();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    task automatic abortar(input string tag);
        errors++;
        $display("FAIL %s: bound expired", tag);
        resumen();
        $fatal(1, "bench stopped");
    endtask

    task automatic check_salidas(input string tag, input int e_estado, input int e_causa);
        check({tag, ".estado"},    32'(estado),    32'(e_estado));
        check({tag, ".alarma"},    32'(alarma),    (e_estado == 3) ? 32'd1 : 32'd0);
        check({tag, ".solicitud"}, 32'(solicitud), (e_estado == 1) ? 32'd1 : 32'd0);
        check({tag, ".causa"},     32'(causa),     32'(e_causa));
        check({tag, ".esperado"},  32'(esperado),  32'(m_esperado));
        check({tag, ".cuenta_ok"}, 32'(cuenta_ok), 32'(m_cuenta));
    endtask

    // Drive idle cycles (habilitar high with probability prob%) until the request pulse,
    // then step into the wait-for-response state.
    task automatic hacer_solicitud(input int prob);
        int  necesarios;
        int  habilitados;
        bit  hab;
        bit  visto;
        necesarios  = PER - m_progreso;
        habilitados = 0;
        visto       = 1'b0;
        error_flag   = 1'b0;
        ack_operador = 1'b0;
        for (int n = 0; n < 1000 && !visto; n++) begin
            hab             = ($urandom_range(99) < 32'(prob));
            habilitar       = hab;
            estado_valido   = ($urandom_range(3) == 0);
            estado_registro = m_esperado[7:0];
            ciclo();
            if (hab) habilitados++;
            if (solicitud === 1'b1) visto = 1'b1;
            else if (habilitados > necesarios + PER) n = 1000;
        end
        if (!visto) abortar("espera_solicitud");
        check("periodo_ciclos", 32'(habilitados), 32'(necesarios));
        m_progreso = 0;
        check_salidas("solicitud", 1, 0);
        habilitar     = $urandom_range(1);
        estado_valido = 1'b0;
        ciclo();
        check_salidas("entrada_espera", 2, 0);
    endtask

    // Reply j cycles after entering the wait state (j in 1..TR), or never if !con_strobe.
    task automatic responder(input int j, input logic [7:0] code, input bit con_strobe,
                             output bit en_falla);
        int e_est;
        int e_causa;
        if (!con_strobe) begin
            for (int k = 1; k < TR; k++) begin
                habilitar       = $urandom_range(1);
                estado_registro = 8'($urandom);
                ciclo();
                check("espera_sin_strobe", 32'(estado), 32'd2);
            end
            ciclo();
            check_salidas("timeout", 3, 3);
            en_falla = 1'b1;
            return;
        end
        for (int k = 1; k < j; k++) begin
            habilitar       = $urandom_range(1);
            estado_valido   = 1'b0;
            estado_registro = 8'($urandom);
            ciclo();
            check("espera_previa", 32'(estado), 32'd2);
        end
        estado_valido   = 1'b1;
        estado_registro = code;
        ciclo();
        estado_valido = 1'b0;
        if (code == CERR) begin
            e_est = 3; e_causa = 1;
        end else if (int'(code) != m_esperado) begin
            e_est = 3; e_causa = 2;
        end else begin
            m_esperado = (m_esperado + 1) % int'(CERR);
            if (m_cuenta < 255) m_cuenta++;
            m_exitos++;
            e_est = 0; e_causa = 0;
        end
        check_salidas("respuesta", e_est, e_causa);
        en_falla = (e_est == 3);
    endtask

    task automatic reconocer();
        error_flag   = 1'b0;
        ack_operador = 1'b1;
        ciclo();
        ack_operador = 1'b0;
        m_progreso   = 0;
        check_salidas("ack", 0, 0);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        resumen();
        $fatal(1, "bench stopped");
    end

    initial begin
        bit         falla;
        int         r;
        logic [7:0] code;

        // Asynchronous reset before any clock edge
        #1 reset_n = 1'b0;
        #1;
        check_salidas("reset_inicial", 0, 0);
        ciclo();
        ciclo();
        @(negedge reloj);
        reset_n = 1'b1;

        // Normal request with habilitar held high: pulse after exactly PER edges
        hacer_solicitud(100);
        responder(1, 8'h00, 1'b1, falla);

        // Timeout, then acknowledge
        hacer_solicitud(100);
        responder(TR, 8'h00, 1'b0, falla);
        reconocer();

        // Advance expected code to 5
        while (m_esperado < 5) begin
            hacer_solicitud(80);
            responder($urandom_range(TR, 1), m_esperado[7:0], 1'b1, falla);
        end
        check("esperado_cinco", 32'(esperado), 32'h05);

        // Sequence mismatch and controller error code keep esperado frozen
        hacer_solicitud(80);
        responder(2, 8'h07, 1'b1, falla);
        check("mismatch_esperado", 32'(esperado), 32'h05);
        reconocer();
        hacer_solicitud(80);
        responder(1, 8'hFF, 1'b1, falla);
        check("error_code_esperado", 32'(esperado), 32'h05);

        // Ack ignored while error_flag is high
        error_flag   = 1'b1;
        ack_operador = 1'b1;
        ciclo();
        check_salidas("ack_con_error", 3, 1);
        reconocer();

        // error_flag in idle and over a correct strobe in the wait state
        habilitar  = 1'b1;
        ciclo();
        m_progreso++;
        error_flag = 1'b1;
        ciclo();
        check_salidas("error_flag_inactivo", 3, 1);
        reconocer();
        hacer_solicitud(100);
        error_flag      = 1'b1;
        estado_valido   = 1'b1;
        estado_registro = m_esperado[7:0];
        ciclo();
        estado_valido = 1'b0;
        check_salidas("error_flag_prioridad", 3, 1);
        reconocer();

        // Strobe in the same cycle as the timeout wins
        hacer_solicitud(80);
        responder(TR, m_esperado[7:0], 1'b1, falla);
        check("strobe_vs_timeout", 32'(estado), 32'd0);

        // Randomized transactions through the esperado wrap and cuenta_ok saturation
        for (int it = 0; it < 700 && m_exitos < 262; it++) begin
            hacer_solicitud(75);
            r = int'($urandom_range(99));
            if (r < 80) begin
                responder($urandom_range(TR, 1), m_esperado[7:0], 1'b1, falla);
            end else if (r < 87) begin
                responder($urandom_range(TR, 1), CERR, 1'b1, falla);
            end else if (r < 94) begin
                code = 8'((m_esperado + 1 + int'($urandom_range(200))) % 255);
                responder($urandom_range(TR, 1), code, 1'b1, falla);
            end else begin
                responder(TR, 8'h00, 1'b0, falla);
            end
            if (falla) reconocer();
        end
        check("exitos_suficientes", (m_exitos >= 260) ? 32'd1 : 32'd0, 32'd1);
        check("saturacion_cuenta", 32'(cuenta_ok), 32'd255);

        // Reset pulsed mid-wait: outputs clear without a clock edge, no further pulse
        hacer_solicitud(80);
        ciclo();
        #3 reset_n = 1'b0;
        #1;
        m_esperado = 0;
        m_cuenta   = 0;
        m_progreso = 0;
        check_salidas("reset_asincrono", 0, 0);
        habilitar = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ciclo();
            check("reset_sin_solicitud", 32'(solicitud), 32'd0);
        end
        @(negedge reloj);
        reset_n = 1'b1;
        hacer_solicitud(100);
        responder(1, 8'h00, 1'b1, falla);

        resumen();
        $finish;
    end

endmodule
